// File: rtl/apf_cram_loader.sv
// APF bridge to CRAM word-port loader. Windowed bridge writes are buffered and
// replayed to the CRAM controller; a single pending read is serviced once the buffer drains.
module apf_cram_loader #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [7:0]  WIN_BASE   = 8'h10
) (
   input  logic        sys_clk,
   input  logic        reset_l_main,
   input  logic        bridge_wr,
   input  logic        bridge_rd,
   input  logic [31:0] bridge_addr,
   input  logic [31:0] bridge_wr_data,
   output logic [31:0] bridge_rd_data,
   output logic        bridge_rd_valid,
   output logic        fifo_full,
   output logic        loader_busy,
   output logic        overflow_err,
   output logic        word_rd,
   output logic        word_wr,
   output logic        word_32bit,
   output logic [23:0] word_addr,
   output logic [31:0] word_data,
   input  logic [31:0] word_q,
   input  logic        word_busy
);

   localparam int unsigned AW    = 24;
   localparam int unsigned DW    = 32;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_entry_t;

   typedef enum logic [2:0] {
      IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, CAPTURE
   } state_t;

   state_t           state_q;
   wr_entry_t        mem_q [FIFO_DEPTH];
   wr_entry_t        head;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, overflow_q, rd_pend_q;
   logic [AW-1:0]    rd_addr_q, word_addr_q;
   logic [DW-1:0]    word_data_q, rd_data_q;
   logic             word_rd_q, word_wr_q, rd_valid_q;
   logic             in_win, full, acc_wr, acc_rd, push, pop, busy_rise;

   assign in_win    = (bridge_addr[31:24] == WIN_BASE);
   assign full      = (count_q == FULL_CNT);
   assign acc_wr    = bridge_wr && in_win;
   assign acc_rd    = bridge_rd && in_win && !rd_pend_q;
   assign push      = acc_wr && !full;
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign busy_rise = word_busy && !busy_q;
   assign head      = mem_q[rd_ptr_q];

   // Fullness is judged on the pre-cycle count, so a push while full is dropped even on a pop.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset_l_main) begin
      if (!reset_l_main) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         busy_q  <= word_busy;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (acc_wr && full) overflow_q <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only read behind a valid count.
   always_ff @(posedge sys_clk) begin
      if (push) mem_q[wr_ptr_q] <= {bridge_addr[23:0], bridge_wr_data};
   end

   always_ff @(posedge sys_clk or negedge reset_l_main) begin
      if (!reset_l_main) begin
         state_q     <= IDLE;
         rd_pend_q   <= 1'b0;
         rd_addr_q   <= '0;
         word_rd_q   <= 1'b0;
         word_wr_q   <= 1'b0;
         word_addr_q <= '0;
         word_data_q <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         if (acc_rd) begin
            rd_pend_q <= 1'b1;
            rd_addr_q <= bridge_addr[23:0];
         end
         case (state_q)
            IDLE: begin
               if (count_q != '0) begin
                  word_addr_q <= head.addr;
                  word_data_q <= head.data;
                  word_wr_q   <= 1'b1;
                  state_q     <= ISSUE_WR;
               end else if (rd_pend_q) begin
                  word_addr_q <= rd_addr_q;
                  word_rd_q   <= 1'b1;
                  state_q     <= ISSUE_RD;
               end
            end
            // Only a fresh rising edge of busy acknowledges the command.
            ISSUE_WR: begin
               if (busy_rise) begin
                  word_wr_q <= 1'b0;
                  state_q   <= WAIT_WR;
               end
            end
            WAIT_WR: begin
               if (!word_busy) state_q <= IDLE;
            end
            ISSUE_RD: begin
               if (busy_rise) begin
                  word_rd_q <= 1'b0;
                  state_q   <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               if (!word_busy) state_q <= CAPTURE;
            end
            CAPTURE: begin
               rd_data_q  <= word_q;
               rd_valid_q <= 1'b1;
               rd_pend_q  <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bridge_rd_data  = rd_data_q;
   assign bridge_rd_valid = rd_valid_q;
   assign fifo_full       = full;
   assign loader_busy     = (count_q != '0) || rd_pend_q || (state_q != IDLE);
   assign overflow_err    = overflow_q;
   assign word_rd         = word_rd_q;
   assign word_wr         = word_wr_q;
   assign word_32bit      = 1'b1;
   assign word_addr       = word_addr_q;
   assign word_data       = word_data_q;

endmodule

// File: tb/tb_apf_cram_loader.sv
// Self-checking bench for apf_cram_loader: directed vector table, hand-written corner
// sequences and randomized bursts scored against an ordered command model.
module tb_apf_cram_loader;

   localparam logic [7:0] WIN = 8'h10;

   typedef struct packed {
      logic        is_wr;
      logic [23:0] addr;
      logic [31:0] data;
   } cmd_t;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rword;
      int          exp_n;
      logic        exp_wr;
      logic [23:0] exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   logic        sys_clk, reset_l_main;
   logic        bridge_wr, bridge_rd;
   logic [31:0] bridge_addr, bridge_wr_data, bridge_rd_data;
   logic        bridge_rd_valid, fifo_full, loader_busy, overflow_err;
   logic        word_rd, word_wr, word_32bit, word_busy;
   logic [23:0] word_addr;
   logic [31:0] word_data, word_q;

   int          n_checks = 0;
   int          n_err    = 0;
   cmd_t        log_q[$];
   cmd_t        exp_q[$];
   logic [31:0] rdq[$];
   logic [31:0] expd_q[$];
   int          wr_rises = 0;
   int          both_cnt = 0;
   logic        wr_prev  = 1'b0;

   logic        auto_en  = 1'b1;
   logic        mdl_hold = 1'b0;
   logic        mdl_busy = 1'b0;
   logic        mdl_act  = 1'b0;
   logic        man_busy = 1'b0;
   int          mdl_lat  = 2;
   int          mdl_dur  = 6;
   logic [31:0] next_rd_word = '0;

   assign word_busy = auto_en ? mdl_busy : man_busy;

   apf_cram_loader #(.FIFO_DEPTH(8), .WIN_BASE(WIN)) dut (
      .sys_clk(sys_clk), .reset_l_main(reset_l_main),
      .bridge_wr(bridge_wr), .bridge_rd(bridge_rd), .bridge_addr(bridge_addr),
      .bridge_wr_data(bridge_wr_data), .bridge_rd_data(bridge_rd_data),
      .bridge_rd_valid(bridge_rd_valid), .fifo_full(fifo_full), .loader_busy(loader_busy),
      .overflow_err(overflow_err), .word_rd(word_rd), .word_wr(word_wr),
      .word_32bit(word_32bit), .word_addr(word_addr), .word_data(word_data),
      .word_q(word_q), .word_busy(word_busy)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic acc(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
      bridge_wr = wr; bridge_rd = rd; bridge_addr = a; bridge_wr_data = d;
      tick();
      bridge_wr = 1'b0; bridge_rd = 1'b0;
   endtask

   task automatic do_reset();
      reset_l_main = 1'b0;
      tick(); tick();
      reset_l_main = 1'b1;
      tick();
   endtask

   task automatic clear_logs();
      log_q.delete(); exp_q.delete(); rdq.delete(); expd_q.delete();
      wr_rises = 0;
   endtask

   // Bounded wait for the loader and the controller model to be quiet for several cycles.
   task automatic wait_idle(input string nm);
      int quiet;
      quiet = 0;
      for (int c = 0; c < 3000 && quiet < 4; c++) begin
         @(negedge sys_clk);
         if (!loader_busy && !mdl_act && !mdl_busy) quiet++;
         else quiet = 0;
      end
      chk({nm, "_idle"}, 64'(quiet >= 4), 64'(1));
      tick();
   endtask

   task automatic cmp_logs(input string nm);
      chk({nm, "_ncmd"}, 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s_cmd%0d", nm, i), 64'(log_q[i]), 64'(exp_q[i]));
      chk({nm, "_nrd"}, 64'(rdq.size()), 64'(expd_q.size()));
      for (int i = 0; i < expd_q.size() && i < rdq.size(); i++)
         chk($sformatf("%s_rd%0d", nm, i), 64'(rdq[i]), 64'(expd_q[i]));
   endtask

   // CRAM controller model: answers each command with busy after mdl_lat cycles for mdl_dur cycles.
   initial begin : cram_model
      logic is_rd;
      word_q = '0;
      forever begin
         tick();
         if (!auto_en) begin
            mdl_busy = 1'b0;
         end else if (mdl_hold) begin
            mdl_busy = 1'b1;
         end else if (mdl_busy) begin
            mdl_busy = 1'b0;
         end else if (word_wr || word_rd) begin
            mdl_act = 1'b1;
            is_rd   = word_rd;
            log_q.push_back('{is_wr: word_wr, addr: word_addr, data: word_wr ? word_data : 32'h0});
            repeat (mdl_lat) tick();
            if (is_rd) word_q = next_rd_word;
            mdl_busy = 1'b1;
            repeat (mdl_dur) tick();
            mdl_busy = 1'b0;
            mdl_act  = 1'b0;
         end
      end
   end

   always @(negedge sys_clk) begin
      if (bridge_rd_valid) rdq.push_back(bridge_rd_data);
      if (word_rd && word_wr) both_cnt <= both_cnt + 1;
      if (word_wr && !wr_prev) wr_rises <= wr_rises + 1;
      wr_prev <= word_wr;
   end

   initial begin : main
      vec_t        vt[9];
      logic [31:0] a, d, rw;
      int          nw, size0, rises0, found;
      logic        with_rd, same_cyc;

      vt[0] = '{1'b1, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 32'h0,         1, 1'b1, 24'h000010, 32'hDEAD_BEEF};
      vt[1] = '{1'b1, 1'b0, 32'h2000_0000, 32'h1234_0000, 32'h0,         0, 1'b0, 24'h0,      32'h0};
      vt[2] = '{1'b1, 1'b0, 32'h10FF_FFFC, 32'h0000_0000, 32'h0,         1, 1'b1, 24'hFFFFFC, 32'h0000_0000};
      vt[3] = '{1'b1, 1'b0, 32'h0F00_0004, 32'hAAAA_AAAA, 32'h0,         0, 1'b0, 24'h0,      32'h0};
      vt[4] = '{1'b1, 1'b0, 32'h1100_0004, 32'h5555_5555, 32'h0,         0, 1'b0, 24'h0,      32'h0};
      vt[5] = '{1'b0, 1'b1, 32'h1000_0100, 32'h0,         32'h1234_5678, 1, 1'b0, 24'h000100, 32'h1234_5678};
      vt[6] = '{1'b0, 1'b1, 32'h9000_0000, 32'h0,         32'h7777_7777, 0, 1'b0, 24'h0,      32'h0};
      vt[7] = '{1'b0, 1'b1, 32'h10AB_CDE0, 32'h0,         32'hA5A5_5A5A, 1, 1'b0, 24'hABCDE0, 32'hA5A5_5A5A};
      vt[8] = '{1'b1, 1'b0, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0,         1, 1'b1, 24'h000000, 32'hFFFF_FFFF};

      reset_l_main = 1'b0;
      bridge_wr = 1'b0; bridge_rd = 1'b0; bridge_addr = '0; bridge_wr_data = '0;
      @(negedge sys_clk);
      chk("rst_ctl", 64'({word_rd, word_wr, word_32bit, fifo_full, overflow_err, loader_busy, bridge_rd_valid}),
          64'(7'b0010000));
      chk("rst_word", 64'({word_addr, word_data}), 64'(0));
      chk("rst_rdata", 64'(bridge_rd_data), 64'(0));
      tick();
      reset_l_main = 1'b1;
      tick();

      // Single accesses from idle, including out-of-window addresses that must leave no trace.
      for (int v = 0; v < 9; v++) begin
         clear_logs();
         next_rd_word = vt[v].rword;
         acc(vt[v].wr, vt[v].rd, vt[v].addr, vt[v].data);
         @(negedge sys_clk);
         chk($sformatf("vec%0d_busy", v), 64'(loader_busy), 64'(vt[v].exp_n != 0));
         wait_idle($sformatf("vec%0d", v));
         chk($sformatf("vec%0d_ncmd", v), 64'(log_q.size()), 64'(vt[v].exp_n));
         chk($sformatf("vec%0d_wrburst", v), 64'(wr_rises), 64'(vt[v].exp_n != 0 && vt[v].exp_wr));
         chk($sformatf("vec%0d_nrd", v), 64'(rdq.size()), 64'(vt[v].exp_n != 0 && !vt[v].exp_wr));
         if (vt[v].exp_n != 0 && log_q.size() > 0)
            chk($sformatf("vec%0d_cmd", v), 64'(log_q[0]),
                64'({vt[v].exp_wr, vt[v].exp_addr, vt[v].exp_wr ? vt[v].exp_data : 32'h0}));
         if (vt[v].exp_n != 0 && !vt[v].exp_wr && rdq.size() > 0)
            chk($sformatf("vec%0d_rdata", v), 64'(rdq[0]), 64'(vt[v].exp_data));
         chk($sformatf("vec%0d_ovf", v), 64'(overflow_err), 64'(0));
      end

      // Write then read of the same word; a second read while one is pending is ignored.
      clear_logs();
      next_rd_word = 32'h1234_5678;
      acc(1'b1, 1'b0, 32'h1000_0100, 32'hCAFE_F00D);
      acc(1'b0, 1'b1, 32'h1000_0100, 32'h0);
      acc(1'b0, 1'b1, 32'h1000_0200, 32'h0);
      exp_q.push_back('{1'b1, 24'h000100, 32'hCAFE_F00D});
      exp_q.push_back('{1'b0, 24'h000100, 32'h0});
      expd_q.push_back(32'h1234_5678);
      wait_idle("wr_rd");
      cmp_logs("wr_rd");

      // Busy already high when the write issues: only a later rising edge releases word_wr.
      clear_logs();
      auto_en  = 1'b0;
      man_busy = 1'b1;
      tick(); tick();
      acc(1'b1, 1'b0, 32'h1000_0040, 32'h1111_1111);
      tick(); tick();
      @(negedge sys_clk);
      chk("hold_busy_high", 64'(word_wr), 64'(1));
      tick();
      man_busy = 1'b0;
      tick(); tick();
      @(negedge sys_clk);
      chk("hold_busy_low", 64'(word_wr), 64'(1));
      tick();
      man_busy = 1'b1;
      @(negedge sys_clk);
      chk("hold_pre_edge", 64'(word_wr), 64'(1));
      tick();
      @(negedge sys_clk);
      chk("release_after_rise", 64'(word_wr), 64'(0));
      tick();
      man_busy = 1'b0;
      tick(); tick();
      @(negedge sys_clk);
      chk("hold_done_idle", 64'(loader_busy), 64'(0));
      chk("hold_one_burst", 64'(wr_rises), 64'(1));
      tick();
      auto_en = 1'b1;
      tick();

      // Overflow: a read stalls the engine on held busy while nine writes arrive back to back.
      do_reset();
      clear_logs();
      mdl_hold = 1'b1;
      tick(); tick();
      next_rd_word = 32'h0BAD_F00D;
      acc(1'b0, 1'b1, 32'h1000_0100, 32'h0);
      tick(); tick();
      exp_q.push_back('{1'b0, 24'h000100, 32'h0});
      expd_q.push_back(32'h0BAD_F00D);
      for (int i = 0; i < 9; i++) begin
         bridge_wr = 1'b1;
         bridge_addr = 32'h1000_0200 + 32'(4 * i);
         bridge_wr_data = 32'hC0DE_0000 + 32'(i);
         if (i < 8) exp_q.push_back('{1'b1, bridge_addr[23:0], bridge_wr_data});
         @(negedge sys_clk);
         if (i == 7) chk("ovf_not_full_at7", 64'(fifo_full), 64'(0));
         if (i == 8) chk("ovf_full_at8", 64'({fifo_full, overflow_err}), 64'(2'b10));
         tick();
      end
      bridge_wr = 1'b0;
      @(negedge sys_clk);
      chk("ovf_flag", 64'({fifo_full, overflow_err}), 64'(2'b11));
      tick();
      mdl_hold = 1'b0;
      wait_idle("ovf");
      cmp_logs("ovf");
      chk("ovf_sticky", 64'(overflow_err), 64'(1));

      // Randomized bursts of writes with an optional trailing read.
      do_reset();
      for (int b = 0; b < 30; b++) begin
         clear_logs();
         mdl_lat  = $urandom_range(0, 3);
         mdl_dur  = $urandom_range(1, 4);
         nw       = $urandom_range(1, 5);
         with_rd  = 1'($urandom_range(0, 1));
         same_cyc = 1'($urandom_range(0, 1));
         rw = $urandom;
         next_rd_word = rw;
         for (int i = 0; i < nw; i++) begin
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:24] = WIN;
            else if (a[31:24] == WIN) a[31:24] = ~WIN;
            if (a[31:24] == WIN) exp_q.push_back('{1'b1, a[23:0], d});
            if (i == nw - 1 && with_rd && same_cyc) begin
               if (a[31:24] == WIN) begin
                  exp_q.push_back('{1'b0, a[23:0], 32'h0});
                  expd_q.push_back(rw);
               end
               acc(1'b1, 1'b1, a, d);
            end else begin
               acc(1'b1, 1'b0, a, d);
            end
            repeat ($urandom_range(0, 2)) tick();
         end
         if (with_rd && !same_cyc) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:24] = WIN;
            else if (a[31:24] == WIN) a[31:24] = ~WIN;
            if (a[31:24] == WIN) begin
               exp_q.push_back('{1'b0, a[23:0], 32'h0});
               expd_q.push_back(rw);
            end
            acc(1'b0, 1'b1, a, 32'h0);
         end
         wait_idle($sformatf("rand%0d", b));
         cmp_logs($sformatf("rand%0d", b));
      end
      chk("rand_no_ovf", 64'(overflow_err), 64'(0));

      // Reset in the middle of a write with three entries still queued.
      mdl_lat = 2;
      mdl_dur = 6;
      clear_logs();
      for (int i = 0; i < 4; i++) acc(1'b1, 1'b0, 32'h1000_0300 + 32'(4 * i), 32'h5000_0000 + 32'(i));
      found = 0;
      for (int c = 0; c < 100 && found == 0; c++) begin
         @(negedge sys_clk);
         if (mdl_busy && mdl_act && !word_wr) found = 1;
      end
      chk("midrst_reach_wait", 64'(found), 64'(1));
      reset_l_main = 1'b0;
      #1;
      chk("midrst_ctl", 64'({word_rd, word_wr, word_32bit, fifo_full, overflow_err, loader_busy, bridge_rd_valid}),
          64'(7'b0010000));
      chk("midrst_word", 64'({word_addr, word_data}), 64'(0));
      chk("midrst_rdata", 64'(bridge_rd_data), 64'(0));
      tick(); tick();
      reset_l_main = 1'b1;
      size0  = log_q.size();
      rises0 = wr_rises;
      repeat (60) tick();
      @(negedge sys_clk);
      chk("midrst_no_retry", 64'(log_q.size()), 64'(size0));
      chk("midrst_no_wr", 64'(wr_rises), 64'(rises0));
      chk("midrst_idle", 64'({loader_busy, fifo_full, word_wr, word_rd}), 64'(0));

      chk("rd_wr_exclusive", 64'(both_cnt), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/apf_cram_loader.md
APF_CRAM_LOADER -- requirements
Module: apf_cram_loader

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8 (power of two, 2..32), giving the write-buffer depth in entries.
REQ-002 The block SHALL have parameter WIN_BASE, default 8'h10, which must match bridge_addr[31:24] for an access to be accepted.
REQ-003 Port sys_clk, input, 1: clock; all logic on its rising edge.
REQ-004 Port reset_l_main, input, 1: reset, asynchronous, active-low.
REQ-005 Port bridge_wr, input, 1: single-cycle write strobe from the APF bridge.
REQ-006 Port bridge_rd, input, 1: single-cycle read strobe from the APF bridge.
REQ-007 Port bridge_addr, input, 32: byte address of the bridge access.
REQ-008 Port bridge_wr_data, input, 32: write data.
REQ-009 Port bridge_rd_data, output, 32: read data, held until the next read completes.
REQ-010 Port bridge_rd_valid, output, 1: one-cycle pulse when bridge_rd_data is updated.
REQ-011 Port fifo_full, output, 1: write buffer holds FIFO_DEPTH entries.
REQ-012 Port loader_busy, output, 1: buffer non-empty, a read is pending, or the state is not IDLE.
REQ-013 Port overflow_err, output, 1: sticky flag, set when a write is dropped.
REQ-014 Ports word_rd, word_wr, word_32bit, output, 1 each: command to the CRAM controller; word_32bit is always 1.
REQ-015 Port word_addr, output, 24: equals bridge_addr[23:0] of the current access.
REQ-016 Port word_data, output, 32: write data of the current access.
REQ-017 Port word_q, input, 32: read data from the controller.
REQ-018 Port word_busy, input, 1: controller busy, registered in the controller.

Function
REQ-019 Window: an access is accepted only if bridge_addr[31:24]==WIN_BASE; any other access is ignored with no flag.
REQ-020 Push: an accepted bridge_wr with count<FIFO_DEPTH pushes {addr[23:0],data}; with count==FIFO_DEPTH it is dropped and overflow_err is set.
REQ-021 Simultaneous push and pop in one cycle: both take effect and count is unchanged; fullness is judged on the pre-cycle count, so a push while full is still dropped.
REQ-022 Read request: an accepted bridge_rd sets rd_pend with its address; a bridge_rd while rd_pend=1 is ignored.
REQ-023 bridge_rd and bridge_wr in the same cycle: both are accepted, and the write precedes the read.
REQ-024 The block SHALL register word_busy into busy_q every cycle.
REQ-025 The state machine SHALL have states IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, CAPTURE.
REQ-026 IDLE: if the FIFO is non-empty -> ISSUE_WR, popping the head into the word_addr/word_data registers; else if rd_pend -> ISSUE_RD; writes always drain before a pending read.
REQ-027 ISSUE_WR: word_wr=1; stays until word_busy=1 && busy_q=0 (rising edge), then deasserts word_wr -> WAIT_WR.
REQ-028 ISSUE_WR: busy already high on entry (other master) is not an edge, so the block keeps holding word_wr.
REQ-029 WAIT_WR: on word_busy=0 -> IDLE.
REQ-030 ISSUE_RD / WAIT_RD: same as ISSUE_WR / WAIT_WR using word_rd; on word_busy=0 in WAIT_RD -> CAPTURE.
REQ-031 CAPTURE: bridge_rd_data<=word_q, bridge_rd_valid=1 for this cycle, rd_pend cleared -> IDLE.
REQ-032 word_rd and word_wr SHALL never both be 1.
REQ-033 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-034 While reset_l_main=0: state=IDLE; FIFO empty; rd_pend=0; busy_q=0.
REQ-035 While reset_l_main=0, outputs: word_rd=0, word_wr=0, word_32bit=1, word_addr=0, word_data=0.
REQ-036 While reset_l_main=0, outputs: bridge_rd_data=0, bridge_rd_valid=0, fifo_full=0, overflow_err=0, loader_busy=0.
REQ-037 Reset asserted mid-transfer SHALL abort immediately; buffered data is discarded and no retry is made.

Verification
REQ-038 Write 0x1000_0010 data 0xDEADBEEF, busy rises 2 cycles later, falls 6 cycles later -> one word_wr burst, word_addr=0x000010, word_data=0xDEADBEEF, then IDLE.
REQ-039 Nine back-to-back writes, word_busy held 1 -> fifo_full=1 after 8, 9th dropped, overflow_err=1; release busy -> exactly 8 writes issued in order.
REQ-040 Write then read of 0x1000_0100, word_q=0x12345678 -> write issued before word_rd; bridge_rd_valid pulses once with 0x12345678.
REQ-041 word_busy already 1 when ISSUE_WR entered, falls, then rises -> word_wr held throughout, released only after the rising edge.
REQ-042 Write to 0x2000_0000 -> no push, no flag, loader_busy stays 0.
REQ-043 Reset pulsed during WAIT_WR with 3 entries queued -> all outputs at reset values, FIFO empty, no further commands issued.
